// File: rtl/sipo_rcv.sv
// sipo_rcv -- serial-in, parallel-out word receiver.
//
// Assembles a framed bit stream into w-bit words and presents each finished
// word on a buffered output register guarded by a valid/ready handshake, so
// the next word can be received while the current one is still waiting to be
// consumed.
//
// Optional feature: define SIPO_RCV_PARITY_EN to expect one even-parity bit
// after every w data bits. The parity result is reported on perr together
// with the word. Without the macro there is no parity phase and perr is 0.
//
// Parameters:
//   w        word width in bits (2..16)
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   rst_b    asynchronous active-low reset
//   sin      serial data bit
//   sin_vld  sin carries a valid bit this cycle
//   frm      first bit of a frame (qualified by sin_vld)
//   sh_dir   0 = MSB first, 1 = LSB first; latched on the first bit of a frame
//   q_rdy    consumer takes q this cycle
//   q        last completed word
//   q_vld    q holds an unconsumed word
//   ovr      sticky overrun flag, cleared only by reset
//   perr     parity error of the word in q (0 without SIPO_RCV_PARITY_EN)
module sipo_rcv #(
  parameter int w = 8
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic         sin,
  input  logic         sin_vld,
  input  logic         frm,
  input  logic         sh_dir,
  input  logic         q_rdy,
  output logic [w-1:0] q,
  output logic         q_vld,
  output logic         ovr,
  output logic         perr
);

  localparam int CW = $clog2(w + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(w - 1);

`ifdef SIPO_RCV_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif

  // Direction 0 shifts toward the MSB, so the first bit lands in bit w-1;
  // direction 1 shifts toward the LSB, so the first bit lands in bit 0.
  function automatic logic [w-1:0] shift_in(input logic [w-1:0] cur,
                                            input logic b,
                                            input logic d);
    if (d)
      return {b, cur[w-1:1]};
    else
      return {cur[w-2:0], b};
  endfunction

`ifdef SIPO_RCV_PARITY_EN
  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic par_err(input logic [w-1:0] data, input logic pb);
    return (^data) ^ pb;
  endfunction
`endif

  state_t        state, state_nxt;
  logic [w-1:0]  sh, sh_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          dir, dir_nxt;

  // A word is finished this edge; done_word is what q would load.
  logic          done;
  logic [w-1:0]  done_word;
`ifdef SIPO_RCV_PARITY_EN
  logic          done_perr;
`endif

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    done      = 1'b0;
    done_word = sh;
`ifdef SIPO_RCV_PARITY_EN
    done_perr = 1'b0;
`endif
    if (sin_vld && frm) begin
      // Frame start. From RECV/PAR this is a resync: the partial word is
      // silently dropped and this bit becomes bit 1 of the new frame.
      dir_nxt   = sh_dir;
      sh_nxt    = shift_in(sh, sin, sh_dir);
      cnt_nxt   = CW'(1);
      state_nxt = RECV;
    end else if (sin_vld) begin
      case (state)
        RECV: begin
          sh_nxt = shift_in(sh, sin, dir);
          if (cnt == LAST_BIT) begin
            cnt_nxt = '0;
`ifdef SIPO_RCV_PARITY_EN
            state_nxt = PAR;
`else
            state_nxt = IDLE;
            done      = 1'b1;
            done_word = sh_nxt;
`endif
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
`ifdef SIPO_RCV_PARITY_EN
        PAR: begin
          state_nxt = IDLE;
          done      = 1'b1;
          done_word = sh;
          done_perr = par_err(sh, sin);
        end
`endif
        default: ;  // IDLE: non-frame bits are ignored
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      q     <= '0;
      q_vld <= 1'b0;
      ovr   <= 1'b0;
`ifdef SIPO_RCV_PARITY_EN
      perr  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
      dir   <= dir_nxt;
      if (done) begin
        // A consumer taking the old word on this same edge frees the
        // buffer, so only an unread buffer counts as an overrun.
        if (q_vld && !q_rdy) begin
          ovr <= 1'b1;
        end else begin
          q     <= done_word;
          q_vld <= 1'b1;
`ifdef SIPO_RCV_PARITY_EN
          perr  <= done_perr;
`endif
        end
      end else if (q_rdy) begin
        q_vld <= 1'b0;
      end
    end
  end

`ifndef SIPO_RCV_PARITY_EN
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rcv.sv
module tb_sipo_rcv;

  localparam int W = 8;
`ifdef SIPO_RCV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_b;
  logic         sin;
  logic         sin_vld;
  logic         frm;
  logic         sh_dir;
  logic         q_rdy;
  logic [W-1:0] q;
  logic         q_vld;
  logic         ovr;
  logic         perr;

  sipo_rcv #(.w(W)) dut (
    .clk    (clk),
    .rst_b  (rst_b),
    .sin    (sin),
    .sin_vld(sin_vld),
    .frm    (frm),
    .sh_dir (sh_dir),
    .q_rdy  (q_rdy),
    .q      (q),
    .q_vld  (q_vld),
    .ovr    (ovr),
    .perr   (perr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         p;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_perr(input logic [W-1:0] d, input logic pb);
    return ((^d) ^ pb) & PAR_EN;
  endfunction

  task automatic push(input logic [W-1:0] d, input logic pb);
    sb.push_back('{d: d, p: exp_perr(d, pb)});
  endtask

  // Every word the consumer takes must be the next expected one.
  always @(negedge clk) begin
    if (rst_b === 1'b1 && q_vld === 1'b1 && q_rdy === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        chk("sb_q", q, e.d);
        chk("sb_perr", perr, e.p);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b   = 1'b0;
    sin_vld = 1'b0;
    frm     = 1'b0;
    q_rdy   = 1'b0;
    step();
    step();
    rst_b = 1'b1;
    step();
  endtask

  // Sends nbits of d (full word when nbits==W), optional gap after bit
  // index gap_at, q_rdy raised on the final bit when rdy_last, and a parity
  // bit pb after a full word when the parity build is active and with_par.
  // sh_dir is inverted after the first bit to show it is latched.
  task automatic send_word(input logic [W-1:0] d, input logic dir, input int nbits,
                           input int gap_at, input int gap_len, input logic rdy_last,
                           input logic pb, input logic with_par);
    logic do_par;
    do_par = PAR_EN && with_par && (nbits == W);
    for (int i = 0; i < nbits; i++) begin
      sin     = dir ? d[i] : d[W-1-i];
      sin_vld = 1'b1;
      frm     = (i == 0);
      sh_dir  = (i == 0) ? dir : ~dir;
      if (rdy_last && !do_par && i == nbits - 1) q_rdy = 1'b1;
      step();
      if (i == gap_at) begin
        sin_vld = 1'b0;
        frm     = 1'b0;
        sin     = 1'b1;
        repeat (gap_len) step();
      end
    end
    if (do_par) begin
      sin     = pb;
      sin_vld = 1'b1;
      frm     = 1'b0;
      if (rdy_last) q_rdy = 1'b1;
      step();
    end
    sin_vld = 1'b0;
    frm     = 1'b0;
  endtask

  initial begin
    rst_b   = 1'b0;
    sin     = 1'b0;
    sin_vld = 1'b0;
    frm     = 1'b0;
    sh_dir  = 1'b0;
    q_rdy   = 1'b0;

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      sin     = 1'($urandom);
      sin_vld = 1'($urandom);
      frm     = 1'($urandom);
      sh_dir  = 1'($urandom);
      q_rdy   = 1'($urandom);
      step();
      chk("rst_q", q, 0);
      chk("rst_q_vld", q_vld, 0);
      chk("rst_ovr", ovr, 0);
      chk("rst_perr", perr, 0);
    end
    q_rdy = 1'b0;
    sin_vld = 1'b0;
    rst_b = 1'b1;
    step();

    // Valid bits without a frame start are ignored in IDLE.
    sin = 1'b1; sin_vld = 1'b1; frm = 1'b0;
    repeat (5) step();
    sin_vld = 1'b0;
    step();
    chk("idle_q_vld", q_vld, 0);
    chk("idle_q", q, 0);

    // MSB first, q_vld high for exactly one cycle.
    q_rdy = 1'b1;
    push(8'hC4, ^8'hC4);
    send_word(8'hC4, 1'b0, W, -1, 0, 1'b0, ^8'hC4, 1'b1);
    chk("msb_q_vld", q_vld, 1);
    chk("msb_q", q, 8'hC4);
    step();
    chk("msb_q_vld_drop", q_vld, 0);

    // LSB first with a 3-cycle gap after bit 4.
    push(8'h23, ^8'h23);
    send_word(8'h23, 1'b1, W, 3, 3, 1'b0, ^8'h23, 1'b1);
    chk("lsb_q_vld", q_vld, 1);
    chk("lsb_q", q, 8'h23);
    step();
    chk("lsb_q_vld_drop", q_vld, 0);

    // Overrun: second word dropped, flag sticky.
    q_rdy = 1'b0;
    push(8'hA5, ^8'hA5);
    send_word(8'hA5, 1'b0, W, -1, 0, 1'b0, ^8'hA5, 1'b1);
    chk("ovr_before", ovr, 0);
    send_word(8'h3C, 1'b0, W, -1, 0, 1'b0, ^8'h3C, 1'b1);
    chk("ovr_q", q, 8'hA5);
    chk("ovr_q_vld", q_vld, 1);
    chk("ovr_set", ovr, 1);
    q_rdy = 1'b1;
    step();
    chk("ovr_drain_q_vld", q_vld, 0);
    chk("ovr_sticky", ovr, 1);

    // Consume and complete on the same edge: not an overrun.
    do_reset();
    chk("ovr_cleared", ovr, 0);
    push(8'h5A, ^8'h5A);
    send_word(8'h5A, 1'b0, W, -1, 0, 1'b0, ^8'h5A, 1'b1);
    push(8'h96, ^8'h96);
    send_word(8'h96, 1'b0, W, -1, 0, 1'b1, ^8'h96, 1'b1);
    chk("simul_q", q, 8'h96);
    chk("simul_q_vld", q_vld, 1);
    chk("simul_ovr", ovr, 0);
    step();
    chk("simul_drain", q_vld, 0);

    // Back-to-back frames with no idle cycle between them.
    push(8'h11, ^8'h11);
    push(8'hE7, ^8'hE7);
    send_word(8'h11, 1'b0, W, -1, 0, 1'b0, ^8'h11, 1'b1);
    send_word(8'hE7, 1'b1, W, -1, 0, 1'b0, ^8'hE7, 1'b1);
    chk("b2b_q", q, 8'hE7);
    step();

    // Resync after 5 bits.
    send_word(8'hFF, 1'b0, 5, -1, 0, 1'b0, 1'b0, 1'b0);
    push(8'h81, ^8'h81);
    send_word(8'h81, 1'b0, W, -1, 0, 1'b0, ^8'h81, 1'b1);
    chk("resync_q", q, 8'h81);
    chk("resync_ovr", ovr, 0);
    step();

`ifdef SIPO_RCV_PARITY_EN
    // Correct and wrong parity.
    push(8'hC4, 1'b1);
    send_word(8'hC4, 1'b0, W, -1, 0, 1'b0, 1'b1, 1'b1);
    chk("par_ok_perr", perr, 0);
    step();
    push(8'hC4, 1'b0);
    send_word(8'hC4, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b1);
    chk("par_bad_perr", perr, 1);
    step();
    // Frame start during the parity phase discards the word.
    send_word(8'h77, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b0);
    push(8'h3C, 1'b0);
    send_word(8'h3C, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b1);
    chk("par_resync_q", q, 8'h3C);
    chk("par_resync_perr", perr, 0);
    step();
`endif

    // Reset in the middle of a frame, with a word still buffered.
    q_rdy = 1'b0;
    push(8'h6B, ^8'h6B);
    send_word(8'h6B, 1'b0, W, -1, 0, 1'b0, 1'b0, 1'b1);
    e = sb.pop_front();  // discarded by the reset below
    send_word(8'hF0, 1'b0, 4, -1, 0, 1'b0, 1'b0, 1'b0);
    rst_b = 1'b0;
    #1;
    chk("midrst_q", q, 0);
    chk("midrst_q_vld", q_vld, 0);
    chk("midrst_ovr", ovr, 0);
    chk("midrst_perr", perr, 0);
    step();
    rst_b = 1'b1;
    q_rdy = 1'b1;
    step();
    push(8'hC4, ^8'hC4);
    send_word(8'hC4, 1'b0, W, -1, 0, 1'b0, ^8'hC4, 1'b1);
    chk("midrst_next_q", q, 8'hC4);
    chk("midrst_next_q_vld", q_vld, 1);
    step();
    step();

    chk("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
